act_dispatch: RTL

- Upstream issue stage for the sigmoid/tanh activation unit.
- Accepts one job descriptor: function select plus element count. Then streams that many data words from a valid/ready source into a registered output stage.
- The output stage drives ACT_EN and FUNC_SEL. These feed the activation unit's enable/select decode, which produces one-hot enables: sigmoid = ACT_EN & FUNC_SEL, tanh = ACT_EN & ~FUNC_SEL.
- Also provides element index and job-complete status to the LSTM sequencer.

---
 rtl/act_dispatch.sv | 107 ++++++++++
 1 files changed

// File: rtl/act_dispatch.sv
// Issue stage for the sigmoid/tanh activation unit: latches a job descriptor,
// then streams LEN data words through a one-entry registered output stage.
module act_dispatch #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              OP_SEL,
  input  logic [LEN_W-1:0]  LEN,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VLD,
  output logic              DIN_RDY,
  input  logic              STALL,
  output logic              ACT_EN,
  output logic              FUNC_SEL,
  output logic [DATA_W-1:0] DOUT,
  output logic [LEN_W-1:0]  IDX,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_t            state_reg, state_next;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  cnt_reg;
  logic              act_en_reg;
  logic              func_sel_reg;
  logic [DATA_W-1:0] dout_reg;
  logic [LEN_W-1:0]  idx_reg;

  logic consume;
  logic accept;
  logic last_accept;
  logic start_ok;

  assign consume     = act_en_reg & ~STALL;
  assign accept      = DIN_VLD & DIN_RDY;
  // cnt_reg < len_reg whenever accept is high, so the increment cannot wrap
  assign last_accept = accept && ((cnt_reg + CNT_ONE) == len_reg);
  assign start_ok    = (state_reg == IDLE) && START;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (START) state_next = (LEN != '0) ? RUN : FIN;
      RUN:     if (last_accept) state_next = DRAIN;
      DRAIN:   if (consume) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    DIN_RDY = 1'b0;
    BUSY    = 1'b1;
    DONE    = 1'b0;
    case (state_reg)
      IDLE:    BUSY = 1'b0;
      // accept only when the output slot is empty or being vacated this cycle
      RUN:     DIN_RDY = (cnt_reg < len_reg) && (!act_en_reg || !STALL);
      DRAIN:   DIN_RDY = 1'b0;
      FIN:     DONE = 1'b1;
      default: BUSY = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      len_reg      <= '0;
      cnt_reg      <= '0;
      act_en_reg   <= 1'b0;
      func_sel_reg <= 1'b0;
      dout_reg     <= '0;
      idx_reg      <= '0;
    end else begin
      if (start_ok) begin
        func_sel_reg <= OP_SEL;
        len_reg      <= LEN;
        cnt_reg      <= '0;
      end
      if (accept) begin
        act_en_reg <= 1'b1;
        dout_reg   <= DIN;
        idx_reg    <= cnt_reg;
        cnt_reg    <= cnt_reg + CNT_ONE;
      end else if (consume) begin
        act_en_reg <= 1'b0;
      end
    end
  end

  assign ACT_EN   = act_en_reg;
  assign FUNC_SEL = func_sel_reg;
  assign DOUT     = dout_reg;
  assign IDX      = idx_reg;

endmodule
